irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NSRC, default 8, number of interrupt sources (fixed 8 for this core; id width 3).
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 irq_src  input  8  raw interrupt lines, rising-edge sensitive, synchronous to clk.
REQ-005 enable_pc  input  1  core instruction-boundary strobe (PC update cycle).
REQ-006 pc  input  32  current PC from the PC/CSR utility block.
REQ-007 opcode  input  12  decoded opcode of the instruction at the boundary.
REQ-008 cfg_we  input  1  config write strobe.
REQ-009 cfg_addr  input  2  config register select.
REQ-010 cfg_wdata  input  32  config write data.
REQ-011 cfg_rdata  output  32  config read data, combinational from cfg_addr.
REQ-012 irr  output  1  interrupt redirect request to the PC block.
REQ-013 irr_dest  output  32  handler target PC.
REQ-014 irr_ret  output  32  saved return PC for RETIRQ.
REQ-015 irq_active  output  1  handler in service.

Function
REQ-016 Registers: addr 0 MASK[7:0] (1 = enabled) plus GIE at bit 31; addr 1 VBASE[31:0], bits [3:0] forced 0 on write; addr 2 PENDING[7:0], read / write-1-to-clear; addr 3 STATUS read-only {irq_active at bit 31, current id at [2:0]}; writes to addr 3 ignored.
REQ-017 Unused read bits SHALL read 0.
REQ-018 Edge detect: PENDING[i] SHALL set in the cycle after irq_src[i] goes 0->1 (previous-sample register).
REQ-019 If an edge set and a W1C clear hit the same bit in the same cycle, set SHALL win.
REQ-020 Eligible = PENDING & MASK[7:0], gated by GIE.
REQ-021 Priority is fixed: lowest index wins.
REQ-022 FSM states: IDLE, REQ, SERVICE.
REQ-023 IDLE -> REQ when eligible != 0; latch winning id; irr = 1 from the next cycle.
REQ-024 In REQ, irr_dest = VBASE + (id * 16); id and irr_dest stay stable while in REQ.
REQ-025 Handshake: take = irr & enable_pc & opcode[6:0] not in {1100011, 1101111, 1100111}. Control-transfer instructions defer the take.
REQ-026 On take: irr_ret <= pc + 4 (32-bit wrap), PENDING[id] cleared, state -> SERVICE, irr deasserts next cycle.
REQ-027 A higher-priority source arriving in REQ before take SHALL NOT change id.
REQ-028 If GIE or MASK[id] is cleared while in REQ, return to IDLE with irr = 0 and PENDING unchanged.
REQ-029 SERVICE: irq_active = 1. Interrupts do not nest; PENDING keeps collecting.
REQ-030 SERVICE -> IDLE on enable_pc & opcode == 12'b001110011000 (RETIRQ); irr_ret held valid until then.
REQ-031 After return, a still-eligible source SHALL be requested again (REQ) the following cycle.
REQ-032 irr SHALL be 0 in IDLE and SERVICE.

Reset
REQ-033 While rst = 0 at a clock edge: state = IDLE; MASK = 0; GIE = 0; VBASE = 0; PENDING = 0; edge samples = 0; id = 0; irr_ret = 0; irr = 0; irr_dest = 0; irq_active = 0.
REQ-034 Reset SHALL override any in-progress REQ/SERVICE and any same-cycle cfg write.

Verification
REQ-035 VBASE = 0x100, MASK = 0x8000_0004, pulse irq_src[2], enable_pc with pc = 0x40 and opcode = LUI -> irr = 1, irr_dest = 0x120; after take, irr_ret = 0x44, irq_active = 1, PENDING[2] = 0.
REQ-036 Sources 5 and 1 rise in the same cycle, both enabled -> id = 1 served first; after RETIRQ, irr reasserts with irr_dest = VBASE + 0x50.
REQ-037 irr high, opcode = 12'b000001101111 (JAL) at enable_pc -> no take, irr stays 1; next boundary with ALU op -> take.
REQ-038 W1C of PENDING[3] in the same cycle as a new irq_src[3] edge -> PENDING[3] reads 1.
REQ-039 rst = 0 asserted while in SERVICE -> next cycle irq_active = 0, irr = 0, cfg_rdata at addr 0/1/2 = 0.
REQ-040 GIE = 0 with PENDING = 0xFF -> irr never asserts; setting GIE -> irr = 1 with id 0 two cycles later.

Source files
------------

// File: rtl/irq_controller.sv
// irq_controller: 8-source edge-triggered interrupt controller with fixed priority, PC redirect handshake and RETIRQ return
module irq_controller #(
  parameter int NSRC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  irq_src,
  input  logic        enable_pc,
  input  logic [31:0] pc,
  input  logic [11:0] opcode,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        irr,
  output logic [31:0] irr_dest,
  output logic [31:0] irr_ret,
  output logic        irq_active
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, state_nx;
  logic [7:0] mask, pending, prev_src, eligible, clr;
  logic [31:0] vbase;
  logic [2:0] id, win;
  logic gie, ctrl, take, ret;
  assign eligible = gie ? pending & mask : 8'h0;
  assign irr = state == REQ && gie && mask[id];
  assign irq_active = state == SERVICE;
  assign ctrl = opcode[6:0] == 7'b1100011 || opcode[6:0] == 7'b1101111 || opcode[6:0] == 7'b1100111;
  assign take = irr && enable_pc && !ctrl;
  assign ret = enable_pc && opcode == 12'b001110011000;
  assign clr = (cfg_we && cfg_addr == 2'd2 ? cfg_wdata[7:0] : 8'h0) | (take ? 8'h1 << id : 8'h0);
  assign cfg_rdata = cfg_addr == 2'd0 ? {gie, 23'b0, mask} :
                     cfg_addr == 2'd1 ? vbase :
                     cfg_addr == 2'd2 ? {24'b0, pending} : {irq_active, 28'b0, id};
  always_comb begin
    win = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) win = eligible[i] ? 3'(i) : win;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = |eligible ? REQ : IDLE;
      REQ:     state_nx = !irr ? IDLE : take ? SERVICE : REQ;
      SERVICE: state_nx = ret ? IDLE : SERVICE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      mask <= 8'h0;
      gie <= 1'b0;
      vbase <= 32'h0;
      pending <= 8'h0;
      prev_src <= 8'h0;
      id <= 3'd0;
      irr_dest <= 32'h0;
      irr_ret <= 32'h0;
    end else begin
      prev_src <= irq_src;
      pending <= (pending & ~clr) | (irq_src & ~prev_src);
      if (state == IDLE && |eligible) begin
        id <= win;
        irr_dest <= vbase + {25'b0, win, 4'b0};
      end
      if (take) irr_ret <= pc + 32'd4;
      if (cfg_we && cfg_addr == 2'd0) begin
        mask <= cfg_wdata[7:0];
        gie <= cfg_wdata[31];
      end
      if (cfg_we && cfg_addr == 2'd1) vbase <= {cfg_wdata[31:4], 4'b0};
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: randomized scoreboard bench for irq_controller against a behavioural model
module tb_irq_controller;
  logic clk = 1'b0, rst = 1'b0, enable_pc = 1'b0, cfg_we = 1'b0;
  logic [7:0] irq_src = 8'h0;
  logic [31:0] pc = 32'h0, cfg_wdata = 32'h0;
  logic [11:0] opcode = 12'h0;
  logic [1:0] cfg_addr = 2'd0;
  logic [31:0] cfg_rdata, irr_dest, irr_ret;
  logic irr, irq_active;
  int tests = 0, fails = 0;
  localparam logic [11:0] LUI = 12'h037, ALU = 12'h033, JAL = 12'h06F, RETIRQ = 12'h398;
  always #5 clk = ~clk;
  irq_controller dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .enable_pc(enable_pc), .pc(pc), .opcode(opcode),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .irr(irr), .irr_dest(irr_dest), .irr_ret(irr_ret), .irq_active(irq_active)
  );
  typedef struct {
    logic irr, act, fresh;
    logic [31:0] rdata, dest, ret;
  } exp_t;
  exp_t sb[$];
  bit [7:0] m_pend, m_mask, m_prev;
  bit m_gie, m_req, m_srv, m_valid, m_fresh;
  bit [31:0] m_vbase, m_dest, m_ret;
  int m_id;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask
  function automatic bit is_ctrl(input logic [11:0] op);
    return op[6:0] == 7'b1100011 || op[6:0] == 7'b1101111 || op[6:0] == 7'b1100111;
  endfunction
  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0: return {m_gie, 23'b0, m_mask};
      2'd1: return m_vbase;
      2'd2: return {24'b0, m_pend};
      default: return {m_srv, 28'b0, 3'(m_id)};
    endcase
  endfunction
  task automatic model_step();
    bit [7:0] edges, clr, elig;
    bit live, take;
    int w;
    if (!rst) begin
      {m_pend, m_mask, m_prev, m_gie, m_req, m_srv} = '0;
      {m_vbase, m_dest, m_ret} = '0;
      m_id = 0;
      m_fresh = 1;
      m_valid = 1;
      return;
    end
    m_fresh = 0;
    edges = irq_src & ~m_prev;
    live = m_req && m_gie && m_mask[m_id];
    take = live && enable_pc && !is_ctrl(opcode);
    clr = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[7:0] : 8'h0;
    if (take) clr[m_id] = 1'b1;
    elig = m_gie ? m_pend & m_mask : 8'h0;
    if (m_req) begin
      if (!live) m_req = 0;
      else if (take) begin
        m_req = 0;
        m_srv = 1;
        m_ret = pc + 32'd4;
      end
    end else if (m_srv) begin
      if (enable_pc && opcode == RETIRQ) m_srv = 0;
    end else if (elig != 0) begin
      w = 0;
      while (!elig[w]) w++;
      m_req = 1;
      m_id = w;
      m_dest = m_vbase + 32'(16 * w);
    end
    if (cfg_we && cfg_addr == 2'd0) begin
      m_mask = cfg_wdata[7:0];
      m_gie = cfg_wdata[31];
    end
    if (cfg_we && cfg_addr == 2'd1) m_vbase = cfg_wdata & ~32'hF;
    m_pend = (m_pend & ~clr) | edges;
    m_prev = irq_src;
  endtask
  task automatic drive(input logic [7:0] s, input logic e, input logic [31:0] p, input logic [11:0] o,
                       input logic w, input logic [1:0] a, input logic [31:0] d, input logic r);
    exp_t x;
    irq_src = s; enable_pc = e; pc = p; opcode = o; cfg_we = w; cfg_addr = a; cfg_wdata = d; rst = r;
    if (m_valid) begin
      x.irr = m_req && m_gie && m_mask[m_id];
      x.act = m_srv;
      x.fresh = m_fresh;
      x.rdata = m_read(a);
      x.dest = m_dest;
      x.ret = m_ret;
      sb.push_back(x);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic nop(input logic [7:0] s); drive(s, 0, 0, 0, 0, cfg_addr, 0, 1); endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d); drive(0, 0, 0, 0, 1, a, d, 1); endtask
  task automatic rd(input logic [1:0] a); drive(0, 0, 0, 0, 0, a, 0, 1); endtask
  task automatic go(input logic [11:0] o, input logic [31:0] p); drive(0, 1, p, o, 0, 0, 0, 1); endtask
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("irr", 32'(irr), 32'(e.irr));
      check("irq_active", 32'(irq_active), 32'(e.act));
      check("cfg_rdata", cfg_rdata, e.rdata);
      if (e.irr || e.fresh) check("irr_dest", irr_dest, e.dest);
      if (e.act || e.fresh) check("irr_ret", irr_ret, e.ret);
    end
  end
  initial begin
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);
    wr(1, 32'h100);
    wr(0, 32'h8000_0004);
    nop(8'h04);
    nop(8'h00);
    check("v35_irr", 32'(irr), 1);
    check("v35_dest", irr_dest, 32'h120);
    go(LUI, 32'h40);
    check("v35_ret", irr_ret, 32'h44);
    check("v35_active", 32'(irq_active), 1);
    check("v35_irr_off", 32'(irr), 0);
    rd(2);
    check("v35_pending", cfg_rdata, 0);
    go(RETIRQ, 0);
    wr(0, 32'h8000_0022);
    nop(8'h22);
    nop(8'h00);
    check("v36_first_dest", irr_dest, 32'h110);
    go(ALU, 32'h80);
    go(RETIRQ, 0);
    nop(8'h00);
    check("v36_reassert", 32'(irr), 1);
    check("v36_dest", irr_dest, 32'h150);
    go(JAL, 32'h90);
    check("v37_jal_irr", 32'(irr), 1);
    check("v37_jal_active", 32'(irq_active), 0);
    go(ALU, 32'h94);
    check("v37_take", 32'(irq_active), 1);
    check("v37_ret", irr_ret, 32'h98);
    go(RETIRQ, 0);
    wr(0, 32'h8000_0000);
    nop(8'h08);
    nop(8'h00);
    drive(8'h08, 0, 0, 0, 1, 2, 32'h08, 1);
    rd(2);
    check("v38_set_wins", cfg_rdata, 32'h08);
    wr(0, 32'h8000_0008);
    nop(8'h00);
    go(ALU, 32'h10);
    check("v39_in_service", 32'(irq_active), 1);
    drive(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0);
    check("v39_active", 32'(irq_active), 0);
    check("v39_irr", 32'(irr), 0);
    for (int a = 0; a < 3; a++) begin
      rd(2'(a));
      check("v39_cfg", cfg_rdata, 0);
    end
    wr(0, 32'h0000_00FF);
    nop(8'hFF);
    nop(8'hFF);
    check("v40_gie_off", 32'(irr), 0);
    wr(0, 32'h8000_00FF);
    check("v40_one_cycle", 32'(irr), 0);
    nop(8'h00);
    check("v40_irr", 32'(irr), 1);
    rd(3);
    check("v40_id", cfg_rdata, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] s;
      logic [11:0] o;
      logic [1:0] a;
      logic [31:0] d;
      int k;
      s = ($urandom % 4 == 0) ? 8'($urandom) : irq_src;
      k = int'($urandom % 6);
      o = k == 0 ? {5'($urandom), 7'h37} : k == 1 ? {5'($urandom), 7'h33} : k == 2 ? {5'($urandom), 7'h6F} :
          k == 3 ? {5'($urandom), 7'h67} : k == 4 ? {5'($urandom), 7'h63} : RETIRQ;
      a = 2'($urandom);
      d = a == 2'd0 ? {($urandom % 4 != 0), 23'($urandom), 8'($urandom)} : $urandom;
      drive(s, ($urandom % 3 == 0), $urandom, o, ($urandom % 10 == 0), a, d, ($urandom % 200 != 0));
    end
    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
